// File: rtl/qconv_seq_pkg.sv
// Shared definitions for the quantized-convolution tile sequencer:
// the state encoding, the stage ordering and the default watchdog limit.
package qconv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_GO    = 3'd1,
    LOAD_WAIT  = 3'd2,
    COMP_GO    = 3'd3,
    COMP_WAIT  = 3'd4,
    STORE_GO   = 3'd5,
    STORE_WAIT = 3'd6,
    DONE       = 3'd7
  } seq_state_e;

  // Every tile begins with the LOAD stage.
  localparam seq_state_e FIRST_STAGE_GO = LOAD_GO;

  // Watchdog limit per stage wait when the timeout feature is built in.
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'h0000_FFFF;

  // Stage order within a tile: LOAD -> COMPUTE -> STORE. Returns the GO
  // state that follows a completed WAIT state; STORE_WAIT is handled by the
  // tile loop in the sequencer itself.
  function automatic seq_state_e stage_after(input seq_state_e wait_state);
    case (wait_state)
      LOAD_WAIT: return COMP_GO;
      COMP_WAIT: return STORE_GO;
      default:   return DONE;
    endcase
  endfunction

  function automatic logic is_wait(input seq_state_e s);
    return (s == LOAD_WAIT) || (s == COMP_WAIT) || (s == STORE_WAIT);
  endfunction

endpackage

// File: rtl/qconv_seq_watchdog.sv
// Per-stage watchdog for the tile sequencer: counts cycles spent in a
// stage wait and flags expiry when the configured limit is reached.
// Only instantiated when QCONV_TILE_SEQ_TIMEOUT_EN is defined.
module qconv_seq_watchdog #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);

  logic [WIDTH-1:0] count_q;

  // Counter clears whenever the sequencer is outside a WAIT state, so every
  // wait starts from zero; it holds once expired instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      count_q <= '0;
    end else if (!expired) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  // The limit-th wait cycle is the one that expires.
  assign expired = run && (count_q == LIMIT - WIDTH'(1));

endmodule

// File: rtl/qconv_tile_sequencer.sv
// Top-level tile sequencer for the quantized-convolution engines.
// Runs num_tiles tiles, each as LOAD -> COMPUTE -> STORE, issuing one-cycle
// start pulses and waiting on each stage's finish input.
// Optional feature: define QCONV_TILE_SEQ_TIMEOUT_EN to add a per-stage
// watchdog that aborts a stuck run with a sticky error flag.
module qconv_tile_sequencer
  import qconv_seq_pkg::*;
#(
  parameter int                       CNT_WIDTH      = 8,
  parameter int                       TIMEOUT_WIDTH  = 16,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = TIMEOUT_WIDTH'(DEFAULT_TIMEOUT_CYCLES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_tiles,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] tile_idx,
  output logic                 load_start,
  output logic                 comp_start,
  output logic                 store_start,
  input  logic                 load_finish,
  input  logic                 comp_finish,
  input  logic                 store_finish
);

  seq_state_e           state, state_next;
  logic [CNT_WIDTH-1:0] tile_idx_q, tile_idx_next;
  logic [CNT_WIDTH-1:0] count_q, count_next;
  logic                 stage_finish;
  logic                 timeout_hit;
  logic                 last_tile;
  logic                 accept_start;

  assign accept_start = (state == IDLE) && start;
  // Full-width compare, so a count of all-ones ends at index all-ones minus one.
  assign last_tile    = (tile_idx_q == count_q - CNT_WIDTH'(1));

`ifdef QCONV_TILE_SEQ_TIMEOUT_EN
  logic error_q;

  qconv_seq_watchdog #(
    .WIDTH (TIMEOUT_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (is_wait(state)),
    .expired (timeout_hit)
  );

  // Error is sticky across the DONE/IDLE states until reset or a new run.
  always_ff @(posedge clk) begin
    if (!rst_n || accept_start) begin
      error_q <= 1'b0;
    end else if (is_wait(state) && !stage_finish && timeout_hit) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign error              = 1'b0;
`endif

  // Only the finish of the stage currently being waited on is observed.
  always_comb begin
    stage_finish = 1'b0;
    case (state)
      LOAD_WAIT:  stage_finish = load_finish;
      COMP_WAIT:  stage_finish = comp_finish;
      STORE_WAIT: stage_finish = store_finish;
      default:    stage_finish = 1'b0;
    endcase
  end

  // Next-state logic: tile loop, stage ordering and watchdog abort.
  // NOTE: every signal gets a default before the case, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    tile_idx_next = tile_idx_q;
    count_next    = count_q;
    case (state)
      IDLE: begin
        if (start) begin
          count_next    = num_tiles;
          tile_idx_next = '0;
          state_next    = (num_tiles == '0) ? DONE : FIRST_STAGE_GO;
        end
      end
      LOAD_GO:  state_next = LOAD_WAIT;
      COMP_GO:  state_next = COMP_WAIT;
      STORE_GO: state_next = STORE_WAIT;
      LOAD_WAIT, COMP_WAIT: begin
        if (stage_finish) begin
          state_next = stage_after(state);
        end else if (timeout_hit) begin
          state_next = DONE;
        end
      end
      STORE_WAIT: begin
        if (stage_finish) begin
          if (last_tile) begin
            state_next = DONE;
          end else begin
            tile_idx_next = tile_idx_q + CNT_WIDTH'(1);
            state_next    = FIRST_STAGE_GO;
          end
        end else if (timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, tile index and latched count registers.
  // NOTE: sequential state is written with non-blocking assignments and the
  // reset is sampled on the clock edge, so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tile_idx_q <= '0;
      count_q    <= '0;
    end else begin
      state      <= state_next;
      tile_idx_q <= tile_idx_next;
      count_q    <= count_next;
    end
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign tile_idx    = tile_idx_q;
  assign load_start  = (state == LOAD_GO);
  assign comp_start  = (state == COMP_GO);
  assign store_start = (state == STORE_GO);

endmodule

// File: doc/qconv_tile_sequencer.md
Name: qconv_tile_sequencer

Overview:
- Top-level controller for the quantized-convolution state machines.
- Runs a programmable number of tiles. Each tile is three stages in fixed order: LOAD, COMPUTE, STORE.
- Each stage is driven by a one-cycle start pulse and completes on that stage's finish signal.
- Sits between the host/CSR start logic and the per-stage qconv state machines; stub state machines substitute for any stage in early integration.

Parameters:
- CNT_WIDTH, 8, width of tile count and tile index.
- TIMEOUT_WIDTH, 16, width of per-stage watchdog counter (used only with the optional feature).
- TIMEOUT_CYCLES, 16'hFFFF, watchdog limit in cycles per stage wait (used only with the optional feature).

Ports:
- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin a run.
- num_tiles  in  CNT_WIDTH  tile count; sampled only when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- error  out  1  sticky timeout flag; tied 0 without the optional feature.
- tile_idx  out  CNT_WIDTH  index of the tile in progress.
- load_start, comp_start, store_start  out  1 each  one-cycle stage start pulses.
- load_finish, comp_finish, store_finish  in  1 each  stage completion.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE, tile_idx to 0, the latched count to 0, error to 0.
  - All outputs are 0 from the following cycle.
  - Reset mid-run aborts the run with no done pulse; any stage start pulse in flight is dropped.
- States: IDLE, LOAD_GO, LOAD_WAIT, COMP_GO, COMP_WAIT, STORE_GO, STORE_WAIT, DONE.
  - State encoding lives in the package.
  - Each stage start output is a pure decode of the state register: load_start = (state==LOAD_GO), and likewise for the other two stages.
- IDLE:
  - start=1 latches num_tiles and clears tile_idx.
  - If num_tiles==0: go to DONE; no stage is started.
  - Otherwise: go to LOAD_GO.
- Stage sequencing:
  - X_GO lasts exactly one cycle, then goes to X_WAIT.
  - X_WAIT stays until X_finish=1 is sampled.
  - LOAD_WAIT then goes to COMP_GO; COMP_WAIT then goes to STORE_GO.
- STORE_WAIT with store_finish=1:
  - If tile_idx == latched_count-1: go to DONE.
  - Otherwise: tile_idx increments by 1 and the state goes to LOAD_GO.
- DONE: done=1 for one cycle, then IDLE. tile_idx holds its last value until the next accepted start.
- Finish inputs are ignored outside their own WAIT state. A finish seen in the GO cycle is not counted. A finish held high continuously (zero-length stage) is accepted in the first WAIT cycle.
- start is ignored whenever state != IDLE, including the DONE cycle. Changes on num_tiles during a run have no effect.
- Timing: start accepted at cycle 0 → LOAD_GO in cycle 1.
  - A stage whose finish arrives N cycles after its start pulse costs N+1 cycles.
  - done rises in cycle 1 + 3·T·(N+1), for T tiles with uniform N.
- Width: count compare uses the full CNT_WIDTH. num_tiles = 2^CNT_WIDTH-1 runs all indices 0..2^CNT_WIDTH-2 with no wrap.

Optional Feature:
- Macro: QCONV_TILE_SEQ_TIMEOUT_EN.
- With the macro:
  - A watchdog counter clears on entry to each WAIT state and increments every WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no finish: error is set (sticky until reset or the next accepted start), the state goes to DONE, and done pulses.
  - finish and timeout in the same cycle: finish wins.
- Without the macro: no counter is instantiated, error is constant 0, and wait states never time out.

Decomposition:
- Package qconv_seq_pkg holds:
  - the state encoding localparams/typedef;
  - the stage order constants;
  - the default TIMEOUT_CYCLES.
- One natural sub-module, qconv_seq_watchdog (counter plus compare), instantiated only under QCONV_TILE_SEQ_TIMEOUT_EN. The FSM stays in the top module.

Test Plan:
- Single tile: all three stages are stub state machines with N=3; num_tiles=1, start pulse in cycle 0.
  - load_start pulses in cycle 1, comp_start in cycle 5, store_start in cycle 9.
  - done pulses in cycle 13; busy is high in cycles 1–13.
- Multi-tile: num_tiles=2, N=3.
  - tile_idx goes 0→1 at the second load_start (cycle 13); done in cycle 25.
  - Exactly 2 pulses on each start output.
- Zero tiles: num_tiles=0.
  - done pulses in cycle 1; no stage start pulses; busy is high for one cycle only.
- Ignored inputs: start re-pulsed in cycle 6 and during DONE; num_tiles changed mid-run; comp_finish forced high during LOAD_WAIT.
  - None alter sequence, count or timing.
- Reset mid-run: rst_n=0 for one cycle during COMP_WAIT of tile 0.
  - busy and tile_idx are 0 from the following cycle; no done pulse.
  - A new start afterwards completes normally.
- Timeout (macro defined, TIMEOUT_CYCLES=8): store_finish is never asserted.
  - error=1 and done pulses 8 cycles after entering STORE_WAIT.
  - The next start clears error.
